// File: rtl/exe_ctrl_update_queue.sv
// In-order FIFO buffering resolved control-transfer results for the predictor/BTB update port.
// Optional statistics counters are enabled with `define UPDATE_QUEUE_STATS_EN.
`ifndef SIZE_PC
`define SIZE_PC 32
`endif
`ifndef BRANCH_TYPE_LOG
`define BRANCH_TYPE_LOG 2
`endif
`ifndef SIZE_CTI_LOG
`define SIZE_CTI_LOG 4
`endif

module exe_ctrl_update_queue #(
  parameter int                          DEPTH     = 4,
  parameter logic [`BRANCH_TYPE_LOG-1:0] COND_TYPE = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        exceptionFlag_i,
  input  logic [`SIZE_PC-1:0]         exeCtrlPC_i,
  input  logic [`BRANCH_TYPE_LOG-1:0] exeCtrlType_i,
  input  logic                        exeCtrlValid_i,
  input  logic [`SIZE_PC-1:0]         exeCtrlNPC_i,
  input  logic                        exeCtrlDir_i,
  input  logic [`SIZE_CTI_LOG-1:0]    exeCtiID_i,
  input  logic                        updReady_i,
  output logic                        updValid_o,
  output logic [`SIZE_PC-1:0]         updPC_o,
  output logic [`SIZE_PC-1:0]         updNPC_o,
  output logic [`BRANCH_TYPE_LOG-1:0] updType_o,
  output logic                        updDir_o,
  output logic                        updCond_o,
  output logic                        updBtbEn_o,
  output logic [`SIZE_CTI_LOG-1:0]    updCtiID_o,
  output logic                        overflow_o
`ifdef UPDATE_QUEUE_STATS_EN
  ,
  output logic [31:0]                 statEnq_o,
  output logic [31:0]                 statDrop_o,
  output logic [$clog2(DEPTH):0]      statMaxOcc_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [`SIZE_PC-1:0]         pcQ   [DEPTH];
  logic [`SIZE_PC-1:0]         npcQ  [DEPTH];
  logic [`BRANCH_TYPE_LOG-1:0] typeQ [DEPTH];
  logic                        dirQ  [DEPTH];
  logic [`SIZE_CTI_LOG-1:0]    ctiQ  [DEPTH];

  logic [PW-1:0] head, tail;
  logic [PW:0]   count, countNext;
  logic          full, deq, enq, drop;

  assign full       = (count == FULL_CNT);
  assign updValid_o = (count != '0);
  assign deq        = updValid_o && updReady_i;
  // A full queue still takes a new entry when the head leaves in the same cycle.
  assign enq        = exeCtrlValid_i && (!full || deq) && !exceptionFlag_i;
  assign drop       = exeCtrlValid_i && full && !deq && !exceptionFlag_i;

  always_comb begin
    countNext = count;
    if (exceptionFlag_i)  countNext = '0;
    else if (enq && !deq) countNext = count + 1'b1;
    else if (deq && !enq) countNext = count - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
    end else begin
      count <= countNext;
      if (drop) overflow_o <= 1'b1;
      if (exceptionFlag_i) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (enq) tail <= tail + PW'(1);
        if (deq) head <= head + PW'(1);
      end
    end
  end

  // Payload storage needs no reset: occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (enq) begin
      pcQ[tail]   <= exeCtrlPC_i;
      npcQ[tail]  <= exeCtrlNPC_i;
      typeQ[tail] <= exeCtrlType_i;
      dirQ[tail]  <= exeCtrlDir_i;
      ctiQ[tail]  <= exeCtiID_i;
    end
  end

  always_comb begin
    updPC_o    = '0;
    updNPC_o   = '0;
    updType_o  = '0;
    updDir_o   = 1'b0;
    updCond_o  = 1'b0;
    updBtbEn_o = 1'b0;
    updCtiID_o = '0;
    if (updValid_o) begin
      updPC_o    = pcQ[head];
      updNPC_o   = npcQ[head];
      updType_o  = typeQ[head];
      updDir_o   = dirQ[head];
      updCond_o  = (typeQ[head] == COND_TYPE);
      updBtbEn_o = dirQ[head];
      updCtiID_o = ctiQ[head];
    end
  end

`ifdef UPDATE_QUEUE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      statEnq_o    <= '0;
      statDrop_o   <= '0;
      statMaxOcc_o <= '0;
    end else begin
      if (enq && statEnq_o != '1)  statEnq_o  <= statEnq_o + 1'b1;
      if (drop && statDrop_o != '1) statDrop_o <= statDrop_o + 1'b1;
      // Flushes drive countNext to zero, so the peak is never lowered.
      if (countNext > statMaxOcc_o) statMaxOcc_o <= countNext;
    end
  end
`endif

endmodule
